// File: rtl/atom_seq_pkg.sv
// Shared types and register map for the atom job sequencer.
package atom_seq_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_COOL} seq_state_e;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_FIFO = 2'd1;
  localparam logic [1:0] ADDR_CNT  = 2'd2;
  localparam logic [1:0] ADDR_RES  = 2'd3;

  localparam int CTRL_RUN       = 0;
  localparam int CTRL_CLR_CNT   = 1;
  localparam int CTRL_CLR_BATCH = 2;

  localparam int STAT_RUN   = 0;
  localparam int STAT_BUSY  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_BATCH = 3;
  localparam int STAT_OVF   = 4;
  localparam int STAT_TMO   = 5;
endpackage

// File: rtl/atom_job_sequencer_if.sv
// Avalon-MM host register port of the job sequencer (read latency 0).
interface atom_job_sequencer_if;
  logic [1:0] address;
  logic       write_n;
  logic [7:0] writedata;
  logic [7:0] readdata;

  modport master (output address, write_n, writedata, input readdata);
  modport slave  (input address, write_n, writedata, output readdata);
endinterface

// File: rtl/atom_seq_fifo.sv
// Show-ahead synchronous FIFO; pushes while full and pops while empty are ignored.
module atom_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_ok, rd_ok;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign wr_ok = push && !full;
  assign rd_ok = pop && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= din;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(wr_ok) - LW'(rd_ok);
    end
  end
endmodule

// File: rtl/atom_job_sequencer.sv
// Dispatches host-queued jobs one at a time to a start/done atom.
// Optional BUSY watchdog enabled by defining ATOM_SEQ_TIMEOUT_EN.
module atom_job_sequencer
  import atom_seq_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  atom_job_sequencer_if.slave  avs,
  output logic                 atom_en,
  output logic [7:0]           atom_arg,
  input  logic                 atom_done,
  input  logic [7:0]           atom_result,
  output logic                 irq
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("atom_job_sequencer: unsupported FIFO_DEPTH or TIMEOUT_CYCLES");
  end

  seq_state_e    state;
  logic          run, ovf, batch, tmo;
  logic [7:0]    done_cnt, last_result;
  logic          wr_ctrl, push, pop, full, empty, expire, clr_cnt;
  logic [7:0]    head;
  logic [LW-1:0] level;

  assign wr_ctrl = !avs.write_n && (avs.address == ADDR_CTRL);
  assign push    = !avs.write_n && (avs.address == ADDR_FIFO);
  assign clr_cnt = wr_ctrl && avs.writedata[CTRL_CLR_CNT];
  assign pop     = (state == ST_IDLE) && run && !empty;
  assign irq     = batch;

  atom_seq_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .din(avs.writedata),
    .dout(head), .full(full), .empty(empty), .level(level)
  );

`ifdef ATOM_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tcnt;

  assign expire = (state == ST_BUSY) && !atom_done && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              tcnt <= '0;
    else if (pop)              tcnt <= '0;
    else if (state == ST_BUSY) tcnt <= tcnt + 1'b1;
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      atom_en     <= 1'b0;
      atom_arg    <= '0;
      run         <= 1'b0;
      ovf         <= 1'b0;
      batch       <= 1'b0;
      tmo         <= 1'b0;
      done_cnt    <= '0;
      last_result <= '0;
    end else begin
      if (wr_ctrl) begin
        run <= avs.writedata[CTRL_RUN];
        if (clr_cnt) begin
          done_cnt <= '0;
          ovf      <= 1'b0;
        end
        if (avs.writedata[CTRL_CLR_BATCH]) begin
          batch <= 1'b0;
          tmo   <= 1'b0;
        end
      end
      if (push && full) ovf <= 1'b1;
      // Later assignments below override the CTRL clears where a set must win.
      case (state)
        ST_IDLE: if (pop) begin
          atom_arg <= head;
          atom_en  <= 1'b1;
          state    <= ST_BUSY;
        end
        ST_BUSY: if (atom_done) begin
          atom_en     <= 1'b0;
          last_result <= atom_result;
          if (!clr_cnt) done_cnt <= done_cnt + 8'd1;
          if (empty)    batch    <= 1'b1;
          state       <= ST_COOL;
        end else if (expire) begin
          atom_en <= 1'b0;
          tmo     <= 1'b1;
          run     <= 1'b0;
          state   <= ST_COOL;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    avs.readdata = '0;
    case (avs.address)
      ADDR_CTRL: avs.readdata = {2'b00, tmo, ovf, batch, empty, state != ST_IDLE, run};
      ADDR_FIFO: avs.readdata = 8'(level);
      ADDR_CNT:  avs.readdata = done_cnt;
      default:   avs.readdata = last_result;
    endcase
  end
endmodule

// File: tb/tb_atom_job_sequencer.sv
// Randomized self-checking bench: job-level scoreboard plus directed test-plan cases.
module tb_atom_job_sequencer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       atom_en, atom_done, irq;
  logic [7:0] atom_arg, atom_result;

  atom_job_sequencer_if bus ();

  atom_job_sequencer #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .avs(bus.slave), .atom_en(atom_en),
    .atom_arg(atom_arg), .atom_done(atom_done), .atom_result(atom_result), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [7:0] exp_q [$];
  int gap_q [$];
  int hi = 0, lo = 0, pulses = 0, done_seen = 0, cur_delay = 1, resp_delay = 1;
  bit resp_on = 1, resp_rand = 0, res_fixed_en = 0;
  logic [7:0] res_fixed = 8'h00, cur_arg = 8'h00;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] res_fn(input logic [7:0] a);
    return res_fixed_en ? res_fixed : 8'(a * 8'd3 + 8'd7);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.address = a; bus.writedata = d; bus.write_n = 1'b0;
    @(posedge clk); #1;
    bus.write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    bus.address = a;
    #1 d = bus.readdata;
  endtask

  task automatic push_job(input logic [7:0] a, input bit expect_dispatch);
    if (expect_dispatch) exp_q.push_back(a);
    wr(2'd1, a);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete(); gap_q.delete();
    hi = 0; lo = 0; pulses = 0; done_seen = 0;
    #7 reset_n = 1'b1;
    cyc(1);
  endtask

  // Atom model: answers each job cur_delay cycles after atom_en rises.
  initial begin
    atom_done = 1'b0; atom_result = 8'h00;
    forever begin
      @(posedge clk); #1;
      atom_done = 1'b0;
      if (atom_en) begin
        if (hi == 0) begin
          pulses++;
          gap_q.push_back(lo);
          lo = 0;
          cur_delay = resp_rand ? int'($urandom_range(1, 6)) : resp_delay;
          cur_arg = atom_arg;
          if (exp_q.size() > 0) chk("disp_arg", atom_arg, exp_q.pop_front());
          else chk("disp_unexpected", 1, 0);
        end
        hi++;
        if (resp_on && hi == cur_delay) begin
          atom_done = 1'b1;
          atom_result = res_fn(cur_arg);
          done_seen++;
        end
      end else begin
        hi = 0;
        lo++;
      end
    end
  end

  logic [7:0] d, last_arg;
  int njobs, n, width;

  initial begin
    bus.address = 2'd0; bus.writedata = 8'h00; bus.write_n = 1'b1;
    do_reset();

    // Reset state
    chk("rst_en", atom_en, 0); chk("rst_arg", atom_arg, 0); chk("rst_irq", irq, 0);
    rd(0, d); chk("rst_status", d, 8'h04);
    rd(1, d); chk("rst_level", d, 0);
    rd(2, d); chk("rst_cnt", d, 0);
    rd(3, d); chk("rst_res", d, 0);

    // Single job
    res_fixed_en = 1; res_fixed = 8'hC3; resp_delay = 10;
    wr(0, 8'h01);
    push_job(8'h5A, 1);
    cyc(1);
    chk("single_en", atom_en, 1); chk("single_arg", atom_arg, 8'h5A);
    cyc(14);
    rd(2, d); chk("single_cnt", d, 1);
    rd(3, d); chk("single_res", d, 8'hC3);
    rd(0, d); chk("single_status", d, 8'h0D);
    chk("single_irq", irq, 1);
    wr(0, 8'h05);
    chk("clr_batch_irq", irq, 0);
    rd(0, d); chk("clr_batch_status", d, 8'h05);
    res_fixed_en = 0;

    // Back-to-back
    do_reset();
    resp_delay = 1;
    for (int i = 0; i < 3; i++) push_job(8'(8'h10 + i), 1);
    gap_q.delete(); pulses = 0;
    wr(0, 8'h01);
    cyc(15);
    chk("b2b_pulses", pulses, 3);
    if (gap_q.size() == 3) begin
      chk("b2b_gap1", gap_q[1], 2);
      chk("b2b_gap2", gap_q[2], 2);
    end else chk("b2b_gapcount", gap_q.size(), 3);
    rd(2, d); chk("b2b_cnt", d, 3);
    rd(1, d); chk("b2b_level", d, 0);
    rd(3, d); chk("b2b_res", d, res_fn(8'h12));

    // Overflow
    do_reset();
    for (int i = 0; i < 9; i++) push_job(8'(i), 0);
    rd(1, d); chk("ovf_level", d, 8);
    rd(0, d); chk("ovf_set", d & 8'h10, 8'h10);
    wr(0, 8'h02);
    rd(0, d); chk("ovf_clr", d & 8'h10, 0);
    rd(1, d); chk("ovf_level_kept", d, 8);
    for (int k = 0; k < 3; k++) begin
      do_reset();
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) push_job(8'($urandom), 0);
      rd(1, d); chk("rovf_level", d, (n > 8) ? 8 : n);
      rd(0, d); chk("rovf_flag", d & 8'h10, (n > 8) ? 8'h10 : 8'h00);
    end

    // Stop mid-job
    do_reset();
    resp_delay = 5;
    push_job(8'hA1, 1);
    push_job(8'hA2, 0);
    wr(0, 8'h01);
    cyc(2);
    wr(0, 8'h00);
    cyc(15);
    rd(2, d); chk("stop_cnt", d, 1);
    rd(1, d); chk("stop_level", d, 1);
    rd(0, d); chk("stop_status", d, 8'h00);
    chk("stop_en", atom_en, 0);

    // Randomized stream against the job scoreboard
    do_reset();
    resp_rand = 1; njobs = 0; last_arg = 8'h00;
    wr(0, 8'h01);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0 && (njobs - done_seen) < 6) begin
        last_arg = 8'($urandom);
        push_job(last_arg, 1);
        njobs++;
      end else cyc(1);
    end
    for (int i = 0; i < 500 && done_seen != njobs; i++) cyc(1);
    chk("rand_drain", done_seen, njobs);
    cyc(3);
    rd(2, d); chk("rand_cnt", d, 8'(njobs));
    if (njobs > 0) begin
      rd(3, d); chk("rand_res", d, res_fn(last_arg));
      rd(0, d); chk("rand_status", d, 8'h0D);
    end
    rd(1, d); chk("rand_level", d, 0);
    chk("rand_queue", exp_q.size(), 0);
    resp_rand = 0;

`ifdef ATOM_SEQ_TIMEOUT_EN
    // Watchdog abort
    do_reset();
    resp_on = 0;
    wr(0, 8'h01);
    push_job(8'h77, 1);
    width = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (atom_en) width++;
      else if (width > 0) break;
    end
    chk("tmo_width", width, 16);
    cyc(2);
    rd(0, d); chk("tmo_status", d, 8'h24);
    rd(2, d); chk("tmo_cnt", d, 0);
    resp_on = 1;
`endif

    // Async reset while busy
    do_reset();
    resp_delay = 100;
    wr(0, 8'h01);
    push_job(8'h3C, 1);
    cyc(3);
    chk("arst_pre_en", atom_en, 1);
    #2 reset_n = 1'b0;
    #1 chk("arst_en", atom_en, 0);
    rd(0, d); chk("arst_status", d, 8'h04);
    rd(1, d); chk("arst_level", d, 0);
    reset_n = 1'b1;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
